addsub_arbiter: RTL and testbench

- Shares one signed two's-complement add/subtract datapath (ripple full-adder chain, carry-in = 1 and inverted B for subtract) between two requesters.
- A round-robin arbiter accepts one operation at a time and latches its operands. It executes the operation in one cycle, then holds the result and overflow flag behind a valid/ready response.
- Sits between the operand-producing front-end blocks and the shared arithmetic unit, so only one adder chain exists in the design.

---
 rtl/addsub_arbiter_pkg.sv | 16 +
 rtl/addsub_arbiter_core.sv | 34 +++
 rtl/full_adder.sv | 14 +
 rtl/addsub_arbiter.sv | 122 ++++++++++++
 tb/tb_addsub_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_arbiter_pkg.sv
// rtl/addsub_arbiter_pkg.sv - shared constants and types for the add/sub arbiter
// Contents: default operand width, operation codes, FSM state encoding.
package addsub_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/addsub_arbiter_core.sv
// rtl/addsub_arbiter_core.sv - combinational signed ripple add/subtract datapath
// Ports: a_i, b_i operands; sub_i selects A-B; sum_o result; ovf_o signed overflow.
module addsub_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;

    // Subtract is A + ~B + 1: invert B and inject the +1 as carry-in.
    assign b_eff    = sub_i ? ~b_i : b_i;
    assign carry[0] = sub_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_eff[i]),
            .c_i (carry[i]),
            .s_o (sum_o[i]),
            .c_o (carry[i+1])
        );
    end

    // Carry into and out of the sign bit differ exactly when both addend
    // signs match and the sum sign differs from them.
    assign ovf_o = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
// Ports: a_i, b_i, c_i (carry in) -> s_o (sum), c_o (carry out).
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin arbiter sharing one add/sub datapath between two requesters
// Ports: clk, rst (sync, active high); req_i/op_i/a*_i/b*_i requests; gnt_o acceptance pulse;
//        rsp_valid_o/rsp_ready_i response handshake with rsp_id_o, rsp_result_o, rsp_ovf_o; busy_o.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    output logic [1:0]       gnt_o,
    output logic             rsp_valid_o,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_ovf_o,
    input  logic             rsp_ready_i,
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       gnt;
    logic             win;
    logic [WIDTH-1:0] core_sum;
    logic             core_ovf;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a_i   (a_q),
        .b_i   (b_q),
        .sub_i (op_q),
        .sum_o (core_sum),
        .ovf_o (core_ovf)
    );

    // On a tie the requester that was not served last wins.
    assign win = (req_i == 2'b11) ? ~last_q : req_i[1];

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rsp_id_d = rsp_id_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        gnt      = 2'b00;
        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    id_d    = win;
                    op_d    = op_i[win];
                    a_d     = win ? a1_i : a0_i;
                    b_d     = win ? b1_i : b0_i;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                gnt[id_q] = 1'b1;
                rsp_id_d  = id_q;
                result_d  = core_ovf ? '0 : core_sum;
                ovf_d     = core_ovf;
                last_d    = id_q;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            rsp_id_q <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rsp_id_q <= rsp_id_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign gnt_o        = gnt;
    assign rsp_valid_o  = (state_q == RESP);
    assign busy_o       = (state_q != IDLE);
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = result_q;
    assign rsp_ovf_o    = ovf_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - self-checking bench for addsub_arbiter
module tb_addsub_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_i;
    logic [1:0]   op_i;
    logic [W-1:0] a0_i, b0_i, a1_i, b1_i;
    logic [1:0]   gnt_o;
    logic         rsp_valid_o;
    logic         rsp_id_o;
    logic [W-1:0] rsp_result_o;
    logic         rsp_ovf_o;
    logic         rsp_ready_i;
    logic         busy_o;

    int checks = 0;
    int errors = 0;

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .op_i         (op_i),
        .a0_i         (a0_i),
        .b0_i         (b0_i),
        .a1_i         (a1_i),
        .b1_i         (b1_i),
        .gnt_o        (gnt_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .rsp_ovf_o    (rsp_ovf_o),
        .rsp_ready_i  (rsp_ready_i),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits on negedges for a grant pulse; returns the number of negedges taken (0 on timeout).
    task automatic wait_gnt(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (gnt_o != 2'b00) begin
                cycles = i;
                break;
            end
        end
        if (cycles == 0) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: got no grant expected one within 10 cycles");
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},    32'(gnt_o),        32'h0);
        check({tag, "_valid"},  32'(rsp_valid_o),  32'h0);
        check({tag, "_id"},     32'(rsp_id_o),     32'h0);
        check({tag, "_result"}, 32'(rsp_result_o), 32'h0);
        check({tag, "_ovf"},    32'(rsp_ovf_o),    32'h0);
        check({tag, "_busy"},   32'(busy_o),       32'h0);
    endtask

    task automatic drive_req(input logic id, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin
            a1_i = a; b1_i = b; op_i[1] = op;
        end else begin
            a0_i = a; b0_i = b; op_i[0] = op;
        end
        req_i[id] = 1'b1;
    endtask

    // Complete one single-requester operation; starts and ends on a negedge in IDLE.
    task automatic run_op(input logic id, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        drive_req(id, op, a, b);
        wait_gnt(n);
        req_i = 2'b00;
        a0_i = '0; b0_i = '0; a1_i = '0; b1_i = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b0, 1'b1, 4'd3,    4'd5,    4'b1110, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 4'd7,    4'b1111, 4'b0000, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 4'd5,    4'd4,    4'b0000, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 4'b1000, 4'b1111, 4'b0000, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 4'b1101, 4'd2,    4'b1111, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 4'b1000, 4'd1,    4'b0000, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 4'd0,    4'b1000, 4'b0000, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 4'd7,    4'b1000, 4'b1111, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 4'd3,    4'd4,    4'd7,    1'b0};

        rst = 1'b1; req_i = 2'b00; op_i = 2'b00;
        a0_i = '0; b0_i = '0; a1_i = '0; b1_i = '0;
        rsp_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Table-driven single-requester operations.
        for (int i = 0; i < 10; i++) begin
            logic [1:0] eg;
            eg = 2'b00;
            eg[vecs[i].id] = 1'b1;
            drive_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_gnt(n);
            check($sformatf("v%0d_latency", i), 32'(n), 32'd1);
            check($sformatf("v%0d_gnt", i), 32'(gnt_o), 32'(eg));
            check($sformatf("v%0d_busy", i), 32'(busy_o), 32'd1);
            req_i = 2'b00;
            a0_i = '0; b0_i = '0; a1_i = '0; b1_i = '0;
            @(negedge clk);
            check($sformatf("v%0d_gnt_off", i), 32'(gnt_o), 32'h0);
            check($sformatf("v%0d_valid", i), 32'(rsp_valid_o), 32'd1);
            check($sformatf("v%0d_id", i), 32'(rsp_id_o), 32'(vecs[i].id));
            check($sformatf("v%0d_result", i), 32'(rsp_result_o), 32'(vecs[i].exp_res));
            check($sformatf("v%0d_ovf", i), 32'(rsp_ovf_o), 32'(vecs[i].exp_ovf));
            @(negedge clk);
            check($sformatf("v%0d_valid_off", i), 32'(rsp_valid_o), 32'd0);
        end

        // Fairness: fresh reset, both requesting continuously.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a0_i = 4'd1; b0_i = 4'd1; a1_i = 4'd2; b1_i = 4'd1;
        op_i = 2'b10;
        req_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic eid;
            eid = (i % 2 == 1);
            wait_gnt(n);
            check($sformatf("rr%0d_gnt", i), 32'(gnt_o), eid ? 32'h2 : 32'h1);
            @(negedge clk);
            check($sformatf("rr%0d_id", i), 32'(rsp_id_o), 32'(eid));
            check($sformatf("rr%0d_result", i), 32'(rsp_result_o), eid ? 32'd1 : 32'd2);
        end
        req_i = 2'b00;
        @(negedge clk);
        @(negedge clk);

        // Backpressure: response held for 5 cycles while both request.
        rsp_ready_i = 1'b0;
        drive_req(1'b0, 1'b0, 4'd2, 4'd3);
        wait_gnt(n);
        req_i = 2'b00;
        @(negedge clk);
        req_i = 2'b11;
        op_i = 2'b00;
        a0_i = 4'd1; b0_i = 4'd1; a1_i = 4'd6; b1_i = 4'd1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_valid", i), 32'(rsp_valid_o), 32'd1);
            check($sformatf("bp%0d_result", i), 32'(rsp_result_o), 32'd5);
            check($sformatf("bp%0d_id", i), 32'(rsp_id_o), 32'd0);
            check($sformatf("bp%0d_ovf", i), 32'(rsp_ovf_o), 32'd0);
            check($sformatf("bp%0d_gnt", i), 32'(gnt_o), 32'd0);
            @(negedge clk);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        check("bp_idle_busy", 32'(busy_o), 32'd0);
        check("bp_idle_valid", 32'(rsp_valid_o), 32'd0);
        @(negedge clk);
        check("bp_next_gnt", 32'(gnt_o), 32'h2);
        req_i = 2'b00;
        @(negedge clk);
        check("bp_next_result", 32'(rsp_result_o), 32'd7);
        @(negedge clk);

        // Reset during EXEC: requester 0 served last, so without reset a tie would go to 1.
        run_op(1'b0, 1'b0, 4'd1, 4'd2);
        drive_req(1'b1, 1'b0, 4'd3, 4'd3);
        wait_gnt(n);
        check("rexec_gnt", 32'(gnt_o), 32'h2);
        rst = 1'b1;
        req_i = 2'b00;
        @(negedge clk);
        check_idle_outputs("rexec");
        rst = 1'b0;
        @(negedge clk);
        check("rexec_no_rsp", 32'(rsp_valid_o), 32'd0);
        req_i = 2'b11;
        wait_gnt(n);
        check("rexec_tie_gnt", 32'(gnt_o), 32'h1);
        req_i = 2'b00;
        @(negedge clk);
        @(negedge clk);

        // Reset during RESP.
        run_op(1'b0, 1'b0, 4'd1, 4'd2);
        rsp_ready_i = 1'b0;
        drive_req(1'b1, 1'b1, 4'd6, 4'd1);
        wait_gnt(n);
        req_i = 2'b00;
        @(negedge clk);
        check("rresp_valid", 32'(rsp_valid_o), 32'd1);
        check("rresp_result", 32'(rsp_result_o), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("rresp");
        rst = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        check("rresp_no_rsp", 32'(rsp_valid_o), 32'd0);
        req_i = 2'b11;
        wait_gnt(n);
        check("rresp_tie_gnt", 32'(gnt_o), 32'h1);
        req_i = 2'b00;
        @(negedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
